// File: rtl/qix_snd_cmd_rx_if.sv
// Sound-CPU register bus for the command receiver.
// One cs strobe per bus cycle, rw sampled with it.
interface qix_snd_cmd_rx_if;
  logic       cs;
  logic       rw;
  logic [1:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       irq_n;

  modport master (
    output cs,
    output rw,
    output addr,
    output data_in,
    input  data_out,
    input  irq_n
  );

  modport slave (
    input  cs,
    input  rw,
    input  addr,
    input  data_in,
    output data_out,
    output irq_n
  );
endinterface

// File: rtl/qix_snd_cmd_rx.sv
// Sound-board receiver for data-CPU sound commands.
// Latches PIA port A on CA2 edge, IRQs, and drives CA1 ack.
module qix_snd_cmd_rx #(
  parameter int unsigned ACK_LEN = 40
) (
  input  logic             clk_20m,
  input  logic             reset_n,
  qix_snd_cmd_rx_if.slave  bus,
  input  logic [7:0]       cmd_in,
  input  logic             cmd_strobe,
  output logic             ack_n
);

  localparam logic [15:0] ACK_LD = 16'(ACK_LEN);

  logic        strobe_prev;
  logic        strobe_edge;
  logic [7:0]  cmd;
  logic [7:0]  count;
  logic [2:0]  ctrl;
  logic        pending;
  logic        overrun;
  logic [15:0] ack_cnt;
  logic        ack_busy;
  logic        ack_start;
  logic        irq_q;

  logic rd;
  logic wr;
  logic rd0;
  logic rd1;
  logic wr1;
  logic wr2;
  logic wr3;

  logic unused_data;
  assign unused_data = ^bus.data_in[7:3];

  assign rd  = bus.cs & bus.rw;
  assign wr  = bus.cs & ~bus.rw;
  assign rd0 = rd & (bus.addr == 2'd0);
  assign rd1 = rd & (bus.addr == 2'd1);
  assign wr1 = wr & (bus.addr == 2'd1);
  assign wr2 = wr & (bus.addr == 2'd2);
  assign wr3 = wr & (bus.addr == 2'd3);

  // Edge follows the real pin history, so a polarity write alone never fires.
  assign strobe_edge = ctrl[2] ? (~strobe_prev & cmd_strobe)
                               : (strobe_prev & ~cmd_strobe);

  assign ack_start = wr3 | (rd0 & ctrl[1]);
  assign ack_busy  = (ack_cnt != 16'd0);

  // Track the strobe pin even in reset so release cannot fake an edge.
  always_ff @(posedge clk_20m) begin
    strobe_prev <= cmd_strobe;
  end

  // Command latch, status flags, counter and control register.
  always_ff @(posedge clk_20m) begin
    if (!reset_n) begin
      cmd     <= 8'h00;
      pending <= 1'b0;
      overrun <= 1'b0;
      count   <= 8'h00;
      ctrl    <= 3'b000;
    end else begin
      if (strobe_edge) begin
        cmd <= cmd_in;
      end
      if (strobe_edge) begin
        pending <= 1'b1;
      end else if (rd0) begin
        pending <= 1'b0;
      end
      if (strobe_edge & pending & ~rd0) begin
        overrun <= 1'b1;
      end else if (rd1) begin
        overrun <= 1'b0;
      end
      if (wr2) begin
        count <= strobe_edge ? 8'h01 : 8'h00;
      end else if (strobe_edge) begin
        count <= count + 8'd1;
      end
      if (wr1) begin
        ctrl <= bus.data_in[2:0];
      end
    end
  end

  // Ack pulse: retrigger reloads, ack_n registered to stay glitch-free.
  always_ff @(posedge clk_20m) begin
    if (!reset_n) begin
      ack_cnt <= 16'd0;
      ack_n   <= 1'b1;
    end else begin
      if (ack_start) begin
        ack_cnt <= ACK_LD;
      end else if (ack_busy) begin
        ack_cnt <= ack_cnt - 16'd1;
      end
      ack_n <= ~(ack_start | (ack_cnt > 16'd1));
    end
  end

  // Interrupt is one register behind the pending/enable state.
  always_ff @(posedge clk_20m) begin
    if (!reset_n) begin
      irq_q <= 1'b1;
    end else begin
      irq_q <= ~(pending & ctrl[0]);
    end
  end

  assign bus.irq_n = irq_q;

  // Read mux shows the pre-access state during the cs cycle.
  always_comb begin
    bus.data_out = 8'h00;
    unique case (bus.addr)
      2'd0: bus.data_out = cmd;
      2'd1: bus.data_out = {pending, overrun, ack_busy,
                            2'b00, ctrl};
      2'd2: bus.data_out = count;
      2'd3: bus.data_out = 8'hFF;
      default: bus.data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_qix_snd_cmd_rx.sv
// Bench for qix_snd_cmd_rx: read data via queue scoreboard,
// pin timing (irq_n, ack_n) checked directly.
module tb_qix_snd_cmd_rx;

  logic       clk_20m;
  logic       reset_n;
  logic [7:0] cmd_in;
  logic       cmd_strobe;
  logic       ack_n;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];

  qix_snd_cmd_rx_if bus();

  qix_snd_cmd_rx #(.ACK_LEN(40)) dut (
    .clk_20m    (clk_20m),
    .reset_n    (reset_n),
    .bus        (bus),
    .cmd_in     (cmd_in),
    .cmd_strobe (cmd_strobe),
    .ack_n      (ack_n)
  );

  initial clk_20m = 1'b0;
  always #5 clk_20m = ~clk_20m;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Monitor: every read cycle pops one expected byte.
  always @(negedge clk_20m) begin
    if (reset_n && bus.cs && bus.rw) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd addr%0d: got %02h, nothing expected",
                 bus.addr, bus.data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.data_out !== e) begin
          errors++;
          $display("FAIL rd addr%0d: got %02h, want %02h",
                   bus.addr, bus.data_out, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_20m);
    #1;
  endtask

  task automatic chk(input string nm, input logic act,
                     input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act,
                         input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e);
    bus.cs = 1'b1;
    bus.rw = 1'b1;
    bus.addr = a;
    exp_q.push_back(e);
    cyc();
    bus.cs = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.cs = 1'b1;
    bus.rw = 1'b0;
    bus.addr = a;
    bus.data_in = d;
    cyc();
    bus.cs = 1'b0;
  endtask

  // Falling CA2 edge (polarity 0), then back high.
  task automatic strobe(input logic [7:0] b);
    cmd_in = b;
    cmd_strobe = 1'b0;
    cyc();
    cmd_strobe = 1'b1;
    cyc();
  endtask

  task automatic wait_ack_idle();
    int n;
    n = 0;
    while (ack_n == 1'b0 && n < 200) begin
      n++;
      cyc();
    end
    chk("ack idle", ack_n, 1'b1);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    cmd_in = 8'h00;
    cmd_strobe = 1'b1;
    bus.cs = 1'b0;
    bus.rw = 1'b1;
    bus.addr = 2'd0;
    bus.data_in = 8'h00;
    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();

    // Reset state
    chk("rst ack_n", ack_n, 1'b1);
    chk("rst irq_n", bus.irq_n, 1'b1);
    rd(2'd1, 8'h00);
    rd(2'd0, 8'h00);
    rd(2'd2, 8'h00);
    rd(2'd3, 8'hFF);

    // Basic capture with IRQ
    wr(2'd1, 8'h01);
    cmd_in = 8'h5A;
    cmd_strobe = 1'b0;
    cyc();
    chk("irq after k", bus.irq_n, 1'b1);
    cmd_strobe = 1'b1;
    cyc();
    chk("irq after k+1", bus.irq_n, 1'b0);
    rd(2'd1, 8'h81);
    rd(2'd2, 8'h01);
    rd(2'd0, 8'h5A);
    chk("irq after clr k", bus.irq_n, 1'b0);
    cyc();
    chk("irq after clr k+1", bus.irq_n, 1'b1);

    // Overrun
    strobe(8'h11);
    strobe(8'h22);
    rd(2'd1, 8'hC1);
    rd(2'd0, 8'h22);
    rd(2'd1, 8'h01);

    // Ack pulse width
    wr(2'd3, 8'h00);
    n = 0;
    while (ack_n == 1'b0 && n < 200) begin
      n++;
      cyc();
    end
    chk_int("ack width", n, 40);

    // Ack retrigger at cycle 20
    wr(2'd3, 8'hA5);
    n = 0;
    while (ack_n == 1'b0 && n < 200) begin
      n++;
      if (n == 20) begin
        wr(2'd3, 8'h00);
      end else begin
        cyc();
      end
    end
    chk_int("ack retrigger", n, 60);

    // Auto-ack on data read
    wr(2'd1, 8'h03);
    strobe(8'h7E);
    rd(2'd0, 8'h7E);
    chk("auto ack", ack_n, 1'b0);
    rd(2'd1, 8'h23);
    wait_ack_idle();

    // Edge coincident with data read
    wr(2'd1, 8'h01);
    strobe(8'h33);
    cmd_in = 8'h44;
    cmd_strobe = 1'b0;
    bus.cs = 1'b1;
    bus.rw = 1'b1;
    bus.addr = 2'd0;
    exp_q.push_back(8'h33);
    cyc();
    bus.cs = 1'b0;
    cmd_strobe = 1'b1;
    cyc();
    rd(2'd1, 8'h81);
    rd(2'd0, 8'h44);

    // Edge coincident with count clear
    cmd_in = 8'h55;
    cmd_strobe = 1'b0;
    wr(2'd2, 8'h9C);
    cmd_strobe = 1'b1;
    cyc();
    rd(2'd2, 8'h01);

    // Count wrap
    wr(2'd2, 8'h00);
    for (int i = 0; i < 256; i++) begin
      strobe(8'(i));
    end
    rd(2'd2, 8'h00);
    rd(2'd1, 8'hC1);
    rd(2'd0, 8'hFF);

    // Rising-edge polarity; polarity write alone is no edge
    wr(2'd1, 8'h04);
    rd(2'd1, 8'h04);
    cmd_in = 8'h66;
    cmd_strobe = 1'b0;
    cyc();
    rd(2'd1, 8'h04);
    cmd_strobe = 1'b1;
    cyc();
    rd(2'd1, 8'h84);
    rd(2'd0, 8'h66);
    wr(2'd1, 8'h00);
    rd(2'd1, 8'h00);

    // Strobe held low through reset release
    reset_n = 1'b0;
    cmd_strobe = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    repeat (2) cyc();
    rd(2'd2, 8'h00);
    rd(2'd1, 8'h00);
    cmd_strobe = 1'b1;
    cyc();

    // Reset mid-ack
    wr(2'd1, 8'h07);
    strobe(8'h99);
    wr(2'd3, 8'h00);
    repeat (5) cyc();
    chk("mid ack low", ack_n, 1'b0);
    reset_n = 1'b0;
    cyc();
    chk("rst ack_n mid", ack_n, 1'b1);
    chk("rst irq_n mid", bus.irq_n, 1'b1);
    reset_n = 1'b1;
    cyc();
    rd(2'd1, 8'h00);
    rd(2'd2, 8'h00);
    rd(2'd0, 8'h00);
    cyc();

    chk_int("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qix_snd_cmd_rx.md
# qix_snd_cmd_rx

Sound-board end of the data-CPU → sound-CPU command link. It captures the command byte that the data CPU's sound PIA drives on port A, qualified by the PIA's CA2 strobe. It then raises an interrupt to the sound CPU and exposes the byte through a small memory-mapped register window. Under sound-CPU control it generates the acknowledge pulse that returns to the data CPU's sound-PIA CA1 input.

## Interface
Parameters:
- ACK_LEN, 40, width of the acknowledge pulse in clk_20m cycles (40 = 2 µs). Legal range 1..65535.

Ports:
- clk_20m  in  1  system clock; the only clock.
- reset_n  in  1  reset, synchronous and active-low.
- cs  in  1  single-cycle bus strobe from the sound CPU, already E-fall qualified. Exactly one pulse per bus cycle.
- rw  in  1  1 = read, 0 = write; sampled with cs.
- addr  in  2  register select.
- data_in  in  8  sound-CPU write data.
- data_out  out  8  read data; combinational mux of the registers selected by addr.
- irq_n  out  1  registered, active-low interrupt to the sound CPU.
- cmd_in  in  8  command byte from the data-side sound PIA port A.
- cmd_strobe  in  1  CA2 from the data-side sound PIA.
- ack_n  out  1  active-low acknowledge pulse to the data-side sound PIA CA1.

## Operation
- Strobe detect:
  - strobe_prev samples cmd_strobe every cycle, including while reset_n = 0. This prevents a spurious edge at reset release.
  - When ctrl[2] = 0, an edge is strobe_prev = 1 and cmd_strobe = 0. When ctrl[2] = 1, an edge is strobe_prev = 0 and cmd_strobe = 1.
  - Writing ctrl[2] never creates an edge by itself.
- On an edge:
  - cmd ← cmd_in.
  - count ← count + 1, 8-bit, wrapping 255 → 0.
  - If pending is already 1, overrun ← 1.
  - pending ← 1.
  - A newer byte always overwrites cmd.
- Register map (an access is cs = 1):
  - addr 0, read: returns cmd. Side effects: pending ← 0. If ctrl[1] = 1, an ack pulse is also started. Writes to addr 0 are ignored.
  - addr 1, read: returns {pending, overrun, ack_busy, 2'b00, ctrl[2:0]}. Side effect: overrun ← 0.
  - addr 1, write: ctrl[2:0] ← data_in[2:0]. ctrl[0] is IRQ enable, ctrl[1] is auto-ack on data read, ctrl[2] is strobe polarity.
  - addr 2, read: returns count.
  - addr 2, write: count ← 0, whatever the data value.
  - addr 3, write: starts an ack pulse, whatever the data value.
  - addr 3, read: returns 8'hFF with no side effects.
- Ack generator:
  - Starting a pulse loads a down-counter with ACK_LEN and drives ack_n = 0. ack_busy = 1 while the counter is nonzero.
  - Starting again while busy reloads the counter to ACK_LEN. The pulse stretches and no glitch occurs.
- irq_n is the registered value of ~(pending & ctrl[0]).
- Simultaneous events:
  - An edge in the same cycle as an addr-0 read: the read returns the old cmd. pending ends at 1, cmd takes the new byte, and overrun is not set.
  - An overrun-setting edge in the same cycle as an addr-1 read: the read returns the pre-edge overrun, and overrun ends at 1.
  - An edge in the same cycle as an addr-2 write: count ends at 1.

## Timing
- Reset values (applied one clock after reset_n is sampled 0): cmd = 0, pending = 0, overrun = 0, ctrl = 0, count = 0, ack counter = 0, ack_n = 1, irq_n = 1.
- A reset during an ack pulse drives ack_n = 1 from the next clock.
- An edge sampled at clock k makes cmd, pending and count valid after clock k. irq_n falls after clock k+1, provided ctrl[0] = 1.
- A read that clears pending at clock k makes irq_n rise after clock k+1.
- An ack started at clock k holds ack_n = 0 from after clock k through after clock k+ACK_LEN−1. ack_n = 1 after clock k+ACK_LEN, giving exactly ACK_LEN cycles low.
- Register side effects take effect on the cs clock. data_out reflects the pre-access state during that cycle.
- Back-to-back edges are accepted as close as every 2 cycles (strobe low for one cycle, then high for one cycle).

## Test plan
- Polarity 0, ctrl = 3'b001, cmd_in = 8'h5A, cmd_strobe 1→0 at clock k:
  - Expected: cmd = 5A and pending = 1 after clock k, irq_n = 0 after clock k+1, count = 1.
  - Then read addr 0: returns 5A, irq_n returns to 1 two clocks later.
- Two strobes (cmd_in 8'h11 then 8'h22) with no read in between:
  - Expected: status reads 8'hC1, then addr 0 returns 22, then status reads 8'h01.
- Write addr 3 with ACK_LEN = 40:
  - Expected: ack_n low for exactly 40 cycles.
  - Re-trigger at cycle 20: ack_n stays low for 60 cycles in total.
- ctrl = 3'b011, strobe with cmd_in = 8'h7E, then read addr 0:
  - Expected: the read returns 7E and ack_n goes low on the next clock.
- Same-cycle cases:
  - Strobe edge on the same clock as an addr-0 read: the read returns the old cmd, pending = 1, overrun = 0, cmd = new value.
  - 256 strobes: count wraps to 0.
- cmd_strobe held low through reset release:
  - Expected: no capture, count = 0.
- Assert reset_n = 0 mid-ack:
  - Expected: ack_n = 1 and all registers at their reset values one clock later.
